// File: rtl/data_mem_if_if.sv
// Data-memory bus bundle between the load/store unit and data memory.
// The master issues requests; the slave returns read data and a one-cycle ack.
interface data_mem_if_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/data_mem_if.sv
// Load/store bus adapter: one outstanding word access, pipeline stall,
// bus-error pulse on misalignment, conflicting request or ack timeout.
module data_mem_if #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        BusErr,
  data_mem_if_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        we_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        any_req;
  logic        bad_req;
  logic        tmo;
  logic        in_req;

  assign any_req = MemRead | MemWrite;
  assign bad_req = (MemRead & MemWrite) | (Addr[1:0] != 2'b00);
  assign tmo     = (cnt_q == 8'(TIMEOUT - 1));
  assign in_req  = (state_q == REQ);

  always_comb begin
    state_d = state_q;
    Stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          Stall   = 1'b1;
          state_d = bad_req ? DONE : REQ;
        end
      end
      REQ: begin
        Stall = 1'b1;
        if (bus.mem_ack || tmo) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) Stall = 1'b0;
  end

  // Ack is checked before the timeout so a same-cycle ack completes cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ReadData <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            err_q <= bad_req;
            if (bad_req) begin
              ReadData <= '0;
            end else begin
              we_q    <= MemWrite;
              addr_q  <= {Addr[31:2], 2'b00};
              wdata_q <= WriteData;
            end
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            cnt_q <= '0;
            err_q <= 1'b0;
            if (!we_q) ReadData <= bus.mem_rdata;
          end else if (tmo) begin
            cnt_q    <= '0;
            err_q    <= 1'b1;
            ReadData <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req   = in_req;
  assign bus.mem_we    = in_req & we_q;
  assign bus.mem_addr  = in_req ? addr_q : '0;
  assign bus.mem_wdata = in_req ? wdata_q : '0;
  assign BusErr        = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_data_mem_if.sv
// Scoreboard bench for data_mem_if: loads, stores, aborts, timeout,
// ack/timeout race, stray ack, back-to-back and reset mid-access.
module tb_data_mem_if;

  localparam int TMO = 16;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          nreq;
    int          nstall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        BusErr;

  data_mem_if_if bus ();

  data_mem_if #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .BusErr    (BusErr),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_chk  = 0;
  int          n_fail = 0;
  exp_t        sb[$];
  logic [31:0] model_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_stall"}, {31'd0, Stall}, 32'd0);
    chk({tag, "_req"}, {31'd0, bus.mem_req}, 32'd0);
    chk({tag, "_berr"}, {31'd0, BusErr}, 32'd0);
    chk({tag, "_addr"}, bus.mem_addr, 32'd0);
  endtask

  // Called at a negedge in an IDLE cycle; returns at a negedge in IDLE.
  task automatic access(input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int ackc, input logic [31:0] rdv,
                        output int first_req, output int done_at);
    exp_t e;
    exp_t g;
    bit   bad;
    bit   tout;
    bit   done;
    int   nreq;
    int   nst;
    bad    = (rd & wr) | (a[1:0] != 2'b00);
    tout   = !bad && (ackc == 0 || ackc > TMO);
    e.err  = bad | tout;
    e.nreq = bad ? 0 : (tout ? TMO : ackc);
    e.rd   = e.err ? 32'd0 : (rd ? rdv : model_rd);
    e.nstall = e.nreq + 1;
    sb.push_back(e);
    model_rd = e.rd;

    MemRead = rd; MemWrite = wr; Addr = a; WriteData = wd;
    #1 chk("stall_c0", {31'd0, Stall}, 32'd1);
    nst = 1; nreq = 0; done = 0;
    first_req = -1; done_at = -1;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        nreq++;
        nst += int'(Stall);
        if (first_req < 0) first_req = cyc;
        chk("mem_we", {31'd0, bus.mem_we}, {31'd0, wr});
        chk("mem_addr", bus.mem_addr, a);
        if (wr) chk("mem_wdata", bus.mem_wdata, wd);
        if (nreq == ackc) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rdv;
        end
      end else if (!Stall) begin
        done = 1; done_at = cyc;
        g = sb.pop_front();
        chk("done_rdata", ReadData, g.rd);
        chk("done_berr", {31'd0, BusErr}, {31'd0, g.err});
        chk("req_cycles", nreq, g.nreq);
        chk("stall_cycles", nst, g.nstall);
      end else begin
        nst++;
      end
    end
    if (!done) chk("done_reached", 32'd0, 32'd1);
    MemRead = 0; MemWrite = 0; Addr = '0; WriteData = '0;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    idle_chk("post_done");
    chk("post_rdata", ReadData, model_rd);
  endtask

  int f1, d1, f2, d2;

  initial begin
    rst = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
    Addr = '0; WriteData = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_rdata", ReadData, 32'd0);
    chk("rst_berr", {31'd0, BusErr}, 32'd0);
    chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
    rst = 1'b0; MemRead = 1'b0;
    @(negedge clk);
    idle_chk("idle0");

    access(1, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF, f1, d1);
    access(0, 1, 32'h204, 32'h12345678, 1, 32'h0, f1, d1);
    access(1, 0, 32'h102, 32'h0, 1, 32'h0, f1, d1);
    access(1, 1, 32'h10, 32'h5, 1, 32'h0, f1, d1);
    access(1, 0, 32'h40, 32'h0, 0, 32'h0, f1, d1);
    access(1, 0, 32'h44, 32'h0, TMO, 32'hA5A5_0001, f1, d1);
    access(0, 1, 32'h103, 32'h77, 1, 32'h0, f1, d1);
    access(1, 0, 32'hC, 32'h0, 2, 32'h0BAD_F00D, f1, d1);

    // stray ack while idle
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    idle_chk("stray_ack");
    chk("stray_rdata", ReadData, model_rd);
    @(negedge clk);
    idle_chk("stray_ack2");

    // back-to-back load then store
    access(1, 0, 32'h80, 32'h0, 1, 32'h1357_9BDF, f1, d1);
    access(0, 1, 32'h8, 32'hCAFE_BABE, 2, 32'h0, f2, d2);
    chk("b2b_gap", f2 - d1, 32'd2);

    // reset in the 2nd REQ cycle, late ack afterwards
    MemRead = 1'b1; Addr = 32'h300;
    @(negedge clk);
    @(negedge clk);
    chk("mid_req", {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    #1 chk("mid_rst_stall", {31'd0, Stall}, 32'd0);
    @(negedge clk);
    idle_chk("mid_rst");
    chk("mid_rst_rdata", ReadData, 32'd0);
    rst = 1'b0; MemRead = 1'b0; Addr = '0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_ABCD;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    idle_chk("late_ack");
    chk("late_ack_rdata", ReadData, 32'd0);
    model_rd = '0;

    access(1, 0, 32'h400, 32'h0, 1, 32'h0F0F_0F0F, f1, d1);

    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
